// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters, with bursts of up to BURST beats.
// Optional build macro ARB_PRIO0_EN: requester 0 wins every arbitration point where it is valid.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int BURST = 4,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [DW-1:0]      fifo_data,
  output logic [IDW-1:0]     grant_id,
  output logic               busy
);

  localparam int             CW          = $clog2(BURST) + 1;
  localparam logic [CW-1:0]  LAST_BEAT   = CW'(BURST - 1);
  localparam logic [IDW-1:0] LAST_ID_RST = IDW'(NREQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] last_id_q, last_id_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;

  logic           any_valid;
  logic [IDW-1:0] winner;
  logic           arb_found;
  logic [IDW-1:0] cand;
  logic           cur_valid;
  logic           beat;
  logic           release_grant;

  assign any_valid = |req_valid;

  // Scan from last_id+1, wrapping modulo NREQ; the first valid requester wins.
  always_comb begin
    winner    = '0;
    arb_found = 1'b0;
    cand      = '0;
`ifdef ARB_PRIO0_EN
    if (req_valid[0]) begin
      winner    = '0;
      arb_found = 1'b1;
    end
`endif
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_id_q) + k) % NREQ);
      for (int i = 0; i < NREQ; i++) begin
`ifdef ARB_PRIO0_EN
        if (!arb_found && i != 0 && cand == IDW'(i) && req_valid[i]) begin
`else
        if (!arb_found && cand == IDW'(i) && req_valid[i]) begin
`endif
          winner    = IDW'(i);
          arb_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    cur_valid = 1'b0;
    fifo_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_q == IDW'(i)) begin
        cur_valid = req_valid[i];
        fifo_data = req_data[i*DW +: DW];
      end
    end
  end

  assign beat          = (state_q == GRANT) && cur_valid && !fifo_full;
  assign release_grant = (state_q == GRANT) &&
                         ((beat && (beat_cnt_q == LAST_BEAT)) || !cur_valid);
  assign fifo_wr_en    = beat;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (beat && grant_id_q == IDW'(i)) req_ready[i] = 1'b1;
    end
  end

  // A release re-arbitrates in the same cycle so back-to-back grants have no bubble.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d    = GRANT;
          grant_id_d = winner;
          last_id_d  = winner;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          beat_cnt_d = '0;
          if (any_valid) begin
            grant_id_d = winner;
            last_id_d  = winner;
          end else begin
            state_d = IDLE;
          end
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      last_id_q  <= LAST_ID_RST;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, then random traffic against a behavioural model.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int BURST = 4;
  localparam int IDW   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    req_ready;
  logic               fifo_full = 1'b0;
  logic               fifo_wr_en;
  logic [DW-1:0]      fifo_data;
  logic [IDW-1:0]     grant_id;
  logic               busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: who holds the port, how many beats it has used, who won last.
  int m_busy, m_gid, m_last, m_cnt;
  logic              exp_busy, exp_wr;
  logic [IDW-1:0]    exp_gid;
  logic [NREQ-1:0]   exp_rdy;
  logic [DW-1:0]     exp_data;
  logic [DW-1:0]     exp_q[$];

  function automatic void model_reset();
    m_busy = 0; m_gid = 0; m_last = NREQ - 1; m_cnt = 0;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    int order[$];
`ifdef ARB_PRIO0_EN
    order.push_back(0);
    for (int k = 1; k <= NREQ; k++)
      if ((last + k) % NREQ != 0) order.push_back((last + k) % NREQ);
`else
    for (int k = 1; k <= NREQ; k++) order.push_back((last + k) % NREQ);
`endif
    foreach (order[j]) if (v[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic void model_cycle(input logic r, input logic [NREQ-1:0] v, input logic f,
                                      input logic [NREQ*DW-1:0] d);
    logic b;
    if (r) model_reset();
    exp_busy = (m_busy != 0);
    exp_gid  = IDW'(m_gid);
    b        = (m_busy != 0) && v[m_gid] && !f;
    exp_wr   = b;
    exp_rdy  = b ? NREQ'(1 << m_gid) : '0;
    exp_data = d[m_gid*DW +: DW];
    if (b) exp_q.push_back(exp_data);
    if (!r) begin
      if (m_busy == 0 || (b && m_cnt == BURST - 1) || !v[m_gid]) begin
        m_cnt = 0;
        if (v != 0) begin
          m_gid  = pick(v, m_last);
          m_last = m_gid;
          m_busy = 1;
        end else begin
          m_busy = 0;
        end
      end else if (b) begin
        m_cnt++;
      end
    end
  endfunction

  task automatic step(input logic r, input logic [NREQ-1:0] v, input logic f);
    logic [NREQ*DW-1:0] d;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) d[i*DW +: DW] = DW'($urandom);
    rst = r; req_valid = v; req_data = d; fifo_full = f;
    #1;
    model_cycle(r, v, f, d);
    check("busy", 32'(busy), 32'(exp_busy));
    check("grant_id", 32'(grant_id), 32'(exp_gid));
    check("fifo_wr_en", 32'(fifo_wr_en), 32'(exp_wr));
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("fifo_data", 32'(fifo_data), 32'(exp_data));
    check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    if (fifo_wr_en) begin
      if (exp_q.size() == 0) check("unexpected_write", 32'(fifo_data), 32'hFFFF_FFFF);
      else check("fifo_stream", 32'(fifo_data), 32'(exp_q.pop_front()));
    end
  endtask

  typedef struct {
    logic            rst;
    logic [NREQ-1:0] valid;
    logic            full;
    logic            wr;
    logic [IDW-1:0]  gid;
    logic            busy;
    logic [NREQ-1:0] rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [NREQ-1:0] v, input logic f, input logic wr,
                              input int gid, input logic b, input logic [NREQ-1:0] rdy);
    vec_t x;
    x.rst = r; x.valid = v; x.full = f; x.wr = wr; x.gid = IDW'(gid); x.busy = b; x.rdy = rdy;
    vecs.push_back(x);
  endfunction

  function automatic void burst(input logic [NREQ-1:0] v, input int gid, input int n);
    for (int i = 0; i < n; i++) add(1'b0, v, 1'b0, 1'b1, gid, 1'b1, NREQ'(1 << gid));
  endfunction

  function automatic void rst_vec();
    add(1'b1, 4'b1111, 1'b0, 1'b0, 0, 1'b0, 4'b0000);
  endfunction

  initial begin
    logic [NREQ-1:0] rv;
    logic            rf, rr;

    model_reset();

    // Sole requester 0 for 6 beats: burst of 4, re-grant to itself, 2 more beats.
    rst_vec();
    add(1'b0, 4'b0001, 1'b0, 1'b0, 0, 1'b0, 4'b0000);
    burst(4'b0001, 0, 6);
    add(1'b0, 4'b0000, 1'b0, 1'b0, 0, 1'b1, 4'b0000);
    add(1'b0, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 4'b0000);

    // All requesters valid: rotation with back-to-back bursts.
    rst_vec();
    add(1'b0, 4'b1111, 1'b0, 1'b0, 0, 1'b0, 4'b0000);
`ifdef ARB_PRIO0_EN
    burst(4'b1111, 0, 17);
`else
    for (int g = 0; g < NREQ; g++) burst(4'b1111, g, 4);
    burst(4'b1111, 0, 1);
`endif

    // Requester 2 stalled by fifo_full after two beats; count holds.
    rst_vec();
    add(1'b0, 4'b0100, 1'b0, 1'b0, 0, 1'b0, 4'b0000);
    burst(4'b0100, 2, 2);
    for (int i = 0; i < 5; i++) add(1'b0, 4'b0100, 1'b1, 1'b0, 2, 1'b1, 4'b0000);
    burst(4'b0100, 2, 2);
    add(1'b0, 4'b0000, 1'b0, 1'b0, 2, 1'b1, 4'b0000);
    add(1'b0, 4'b0000, 1'b0, 1'b0, 2, 1'b0, 4'b0000);

    // Requester 1 drops valid after one beat; requester 3 takes over next cycle.
    rst_vec();
    add(1'b0, 4'b1010, 1'b0, 1'b0, 0, 1'b0, 4'b0000);
    burst(4'b1010, 1, 1);
    add(1'b0, 4'b1000, 1'b0, 1'b0, 1, 1'b1, 4'b0000);
    burst(4'b1000, 3, 1);
    add(1'b0, 4'b0000, 1'b0, 1'b0, 3, 1'b1, 4'b0000);
    add(1'b0, 4'b0000, 1'b0, 1'b0, 3, 1'b0, 4'b0000);

    // Reset mid-burst, then requester 0 wins first.
    rst_vec();
    add(1'b0, 4'b0100, 1'b0, 1'b0, 0, 1'b0, 4'b0000);
    burst(4'b0100, 2, 2);
    rst_vec();
    add(1'b0, 4'b1111, 1'b0, 1'b0, 0, 1'b0, 4'b0000);
    burst(4'b1111, 0, 1);

    // Requester 0 idle: rotation 1,2,3,1.
    rst_vec();
    add(1'b0, 4'b1110, 1'b0, 1'b0, 0, 1'b0, 4'b0000);
    burst(4'b1110, 1, 4);
    burst(4'b1110, 2, 4);
    burst(4'b1110, 3, 4);
    burst(4'b1110, 1, 4);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].valid, vecs[i].full);
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d.grant_id", i), 32'(grant_id), 32'(vecs[i].gid));
      check($sformatf("vec%0d.wr_en", i), 32'(fifo_wr_en), 32'(vecs[i].wr));
      check($sformatf("vec%0d.ready", i), 32'(req_ready), 32'(vecs[i].rdy));
    end

    // Random traffic: sticky valids, frequent full, rare resets.
    rv = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 3) rv = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      rf = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 299) == 0);
      step(rr, rv, rf);
    end
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
